uart_8250_ctrl: RTL and testbench
=================================

Name: uart_8250_ctrl

Overview:
- Wishbone master that configures and services the uart_8250 slave.
- After reset it runs a fixed register-init sequence: DLAB, divisor, line format, FIFO and IER.
- It then arbitrates the single bus between two requesters:
  - a byte-stream TX client;
  - an RX poller that drains received bytes.
- It sits between uart_8250 and any core-side producer/consumer that must not touch UART registers directly.

Parameters:
- BASE_ADDR, 32'h1250_0000, UART register base; registers are at byte offsets +0..+5.
- DIVISOR, 16'h0003, baud divisor written to DLL (+0) and DLM (+1) while DLAB=1.
- LCR_FMT, 8'h03, final LCR value (8N1, DLAB=0).
- POLL_INTERVAL, 16, idle cycles between RX LSR polls when INT_I is low.
- ACK_TIMEOUT, 255, cycles to wait for ACK_I before abandoning a transaction.

Ports:
- CLK_I  in  1  system clock; all state on rising edge.
- RST_I  in  1  asynchronous, active-high reset.
- ADR_O  out  32  Wishbone address; BASE_ADDR + register offset.
- DAT_O  out  32  write data; byte in [7:0], [31:8]=0.
- DAT_I  in  32  read data; only [7:0] used.
- WE_O  out  1  1=write, 0=read.
- SEL_O  out  4  byte select; constant 4'b0001 during a cycle, 0 otherwise.
- STB_O  out  1  Wishbone strobe.
- ACK_I  in  1  Wishbone acknowledge from uart_8250.
- CYC_O  out  1  Wishbone cycle.
- INT_I  in  1  UART interrupt; high forces an RX poll as soon as the bus is free.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  one-entry TX buffer empty and init_done.
- rx_data  out  8  received byte; holds until next rx_valid.
- rx_valid  out  1  one-cycle pulse per received byte.
- init_done  out  1  high once the init sequence has completed.
- bus_err  out  1  sticky; set on ACK timeout.
- err_clr  in  1  clears bus_err.

Behaviour:
- Reset values: all outputs 0, ADR_O=0, state INIT_DLAB, TX buffer empty, poll counter 0. Assertion mid-transaction drops CYC_O/STB_O immediately and the init sequence restarts.
- Bus transaction (handled by the sub-module):
  - Issue: ADR_O/DAT_O/WE_O/SEL_O/CYC_O/STB_O registered together and held until ACK_I is sampled high.
  - End: at the ACK edge, read data is captured and CYC_O/STB_O drop. There is at least one idle cycle before the next STB_O.
  - Timeout: if ACK_TIMEOUT cycles elapse without ACK_I, CYC_O/STB_O drop, bus_err sets and the captured read data is 8'h00.
- Init sequence, all writes, in order:
  - INIT_DLAB: +3 <= 8'h80
  - INIT_DLL: +0 <= DIVISOR[7:0]
  - INIT_DLM: +1 <= DIVISOR[15:8]
  - INIT_LCR: +3 <= LCR_FMT
  - INIT_FCR: +2 <= 8'h07
  - INIT_IER: +1 <= 8'h01
  - Then IDLE with init_done=1. A timed-out init write still advances.
- TX buffer:
  - Accept on tx_valid && tx_ready; tx_ready is low from the next cycle until the THR write is acknowledged.
- IDLE arbitration:
  - Requests: tx_req = buffer full; rx_req = (poll counter == POLL_INTERVAL) || INT_I.
  - Both requesting: grant the one not granted last (last_grant flag, reset to RX). Only one requesting: grant it.
  - The poll counter increments in IDLE saturating at POLL_INTERVAL and clears on every RX grant.
- TX path:
  - TX_LSR: read +5.
  - If LSR[5] (THRE) = 1 -> TX_THR: write +0 <= buffer, buffer empties at ACK. Else return to IDLE; buffer is retained and retried.
- RX path:
  - RX_LSR: read +5.
  - If LSR[0] (DR) = 1 -> RX_RBR: read +0, then rx_data <= DAT_I[7:0] and rx_valid pulses in the cycle after ACK. Else return to IDLE.
- Error flag: bus_err set and err_clr in the same cycle -> set wins. bus_err never blocks operation.

Decomposition:
- Package uart_8250_pkg holds:
  - register offsets (RBR_THR=0, IER=1, IIR_FCR=2, LCR=3, LSR=5);
  - LSR bit indices (DR=0, THRE=5);
  - the controller state enum;
  - init constants 8'h80, 8'h07, 8'h01.
- Sub-module uart_8250_wb_port: single-transaction Wishbone engine with start/done/rdata/timeout. The controller FSM drives it.

Test Plan:
- Reset then slave with zero-wait ACK -> exactly six writes in order (3:80, 0:03, 1:00, 3:03, 2:07, 1:01), then init_done=1, SEL_O=4'b0001 on each cycle.
- tx_data=8'h12 with LSR returning 8'h20 -> one read of 0x1250_0005, then write 0x1250_0000 data 8'h12; tx_ready low until that ACK.
- LSR returns 8'h00 three times, then 8'h20 for tx_data=8'h34 -> three LSR reads with no THR write, then THR write 8'h34; no byte lost or duplicated.
- INT_I=1 with LSR=8'h01 and RBR=8'h56 -> RBR read, rx_data=8'h56, rx_valid high for exactly 1 cycle. With both TX and RX pending, grants alternate TX/RX/TX.
- Slave never ACKs during INIT_DLL -> CYC_O drops after 255 cycles, bus_err=1, sequence continues. err_clr then clears bus_err.
- RST_I pulsed while STB_O high in TX_THR -> CYC_O/STB_O=0 immediately; init sequence restarts; TX buffer empty.

Source files
------------

// File: rtl/uart_8250_pkg.sv
// Shared definitions for the uart_8250 controller: register map, LSR bits,
// init constants and the controller state encoding.
package uart_8250_pkg;

  localparam logic [2:0] REG_RBR_THR = 3'd0;
  localparam logic [2:0] REG_IER     = 3'd1;
  localparam logic [2:0] REG_IIR_FCR = 3'd2;
  localparam logic [2:0] REG_LCR     = 3'd3;
  localparam logic [2:0] REG_LSR     = 3'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;

  localparam logic [7:0] LCR_DLAB_SET = 8'h80;
  localparam logic [7:0] FCR_INIT     = 8'h07;
  localparam logic [7:0] IER_INIT     = 8'h01;

  typedef enum logic [3:0] {
    INIT_DLAB,
    INIT_DLL,
    INIT_DLM,
    INIT_LCR,
    INIT_FCR,
    INIT_IER,
    IDLE,
    TX_LSR,
    TX_THR,
    RX_LSR,
    RX_RBR
  } ctrl_state_t;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [2:0] off);
    return base + {29'd0, off};
  endfunction

endpackage

// File: rtl/uart_8250_wb_port.sv
// Single-transaction Wishbone engine: issues one byte-lane cycle on start and
// reports completion (ACK or timeout) combinationally in the ending cycle.
module uart_8250_wb_port
  import uart_8250_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1250_0000,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  off,
  input  logic [7:0]  wdata,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  rdata,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_wdata,
  input  logic [7:0]  wb_rdata,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic        wb_stb,
  input  logic        wb_ack,
  output logic        wb_cyc
);

  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  logic [15:0] timer;
  logic        tmo_hit;

  assign tmo_hit = (timer == TMO_LAST);
  assign done    = wb_cyc && (wb_ack || tmo_hit);
  assign timeout = wb_cyc && !wb_ack && tmo_hit;
  // A timed-out read hands back zero so callers never act on stale LSR bits.
  assign rdata   = (wb_cyc && wb_ack) ? wb_rdata : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_adr   <= 32'h0;
      wb_wdata <= 32'h0;
      wb_we    <= 1'b0;
      wb_sel   <= 4'b0000;
      wb_stb   <= 1'b0;
      wb_cyc   <= 1'b0;
      timer    <= 16'h0;
    end else if (!wb_cyc) begin
      if (start) begin
        wb_adr   <= reg_addr(BASE_ADDR, off);
        wb_wdata <= {24'h0, wdata};
        wb_we    <= we;
        wb_sel   <= 4'b0001;
        wb_stb   <= 1'b1;
        wb_cyc   <= 1'b1;
        timer    <= 16'h0;
      end
    end else if (done) begin
      wb_sel <= 4'b0000;
      wb_stb <= 1'b0;
      wb_cyc <= 1'b0;
    end else begin
      timer <= timer + 16'd1;
    end
  end

endmodule

// File: rtl/uart_8250_ctrl.sv
// Wishbone master that initialises a uart_8250 and then shares the bus
// between a one-byte TX buffer and an LSR-polling RX drain.
module uart_8250_ctrl
  import uart_8250_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h1250_0000,
  parameter logic [15:0] DIVISOR       = 16'h0003,
  parameter logic [7:0]  LCR_FMT       = 8'h03,
  parameter int          POLL_INTERVAL = 16,
  parameter int          ACK_TIMEOUT   = 255
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic        STB_O,
  input  logic        ACK_I,
  output logic        CYC_O,
  input  logic        INT_I,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        init_done,
  output logic        bus_err,
  input  logic        err_clr
);

  localparam logic [15:0] POLL_MAX = 16'(POLL_INTERVAL);

  ctrl_state_t state, state_next;

  logic        start;
  logic        req_we;
  logic [2:0]  req_off;
  logic [7:0]  req_data;
  logic        done;
  logic        timeout;
  logic [7:0]  rdata;
  logic        tx_full;
  logic [7:0]  tx_buf;
  logic        last_tx;
  logic [15:0] poll_cnt;
  logic        tx_req;
  logic        rx_req;
  logic        grant_tx;
  logic        grant_rx;
  logic        tx_accept;
  logic        unused_dat_hi;

  assign unused_dat_hi = ^DAT_I[31:8];

  assign tx_req    = tx_full;
  assign rx_req    = (poll_cnt == POLL_MAX) || INT_I;
  assign tx_ready  = !tx_full && init_done;
  assign tx_accept = tx_valid && tx_ready;

  uart_8250_wb_port #(
    .BASE_ADDR   (BASE_ADDR),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_port (
    .clk      (CLK_I),
    .rst      (RST_I),
    .start    (start),
    .we       (req_we),
    .off      (req_off),
    .wdata    (req_data),
    .done     (done),
    .timeout  (timeout),
    .rdata    (rdata),
    .wb_adr   (ADR_O),
    .wb_wdata (DAT_O),
    .wb_rdata (DAT_I[7:0]),
    .wb_we    (WE_O),
    .wb_sel   (SEL_O),
    .wb_stb   (STB_O),
    .wb_ack   (ACK_I),
    .wb_cyc   (CYC_O)
  );

  // Every non-IDLE state owns exactly one bus cycle, issued on entry.
  always_comb begin
    state_next = state;
    req_we     = 1'b0;
    req_off    = REG_LSR;
    req_data   = 8'h00;
    grant_tx   = 1'b0;
    grant_rx   = 1'b0;
    unique case (state)
      INIT_DLAB: begin
        req_we   = 1'b1;
        req_off  = REG_LCR;
        req_data = LCR_DLAB_SET;
        if (done) state_next = INIT_DLL;
      end
      INIT_DLL: begin
        req_we   = 1'b1;
        req_off  = REG_RBR_THR;
        req_data = DIVISOR[7:0];
        if (done) state_next = INIT_DLM;
      end
      INIT_DLM: begin
        req_we   = 1'b1;
        req_off  = REG_IER;
        req_data = DIVISOR[15:8];
        if (done) state_next = INIT_LCR;
      end
      INIT_LCR: begin
        req_we   = 1'b1;
        req_off  = REG_LCR;
        req_data = LCR_FMT;
        if (done) state_next = INIT_FCR;
      end
      INIT_FCR: begin
        req_we   = 1'b1;
        req_off  = REG_IIR_FCR;
        req_data = FCR_INIT;
        if (done) state_next = INIT_IER;
      end
      INIT_IER: begin
        req_we   = 1'b1;
        req_off  = REG_IER;
        req_data = IER_INIT;
        if (done) state_next = IDLE;
      end
      IDLE: begin
        if (tx_req && (!rx_req || !last_tx)) begin
          grant_tx   = 1'b1;
          state_next = TX_LSR;
        end else if (rx_req) begin
          grant_rx   = 1'b1;
          state_next = RX_LSR;
        end
      end
      TX_LSR: begin
        if (done) state_next = rdata[LSR_THRE] ? TX_THR : IDLE;
      end
      TX_THR: begin
        req_we   = 1'b1;
        req_off  = REG_RBR_THR;
        req_data = tx_buf;
        if (done) state_next = IDLE;
      end
      RX_LSR: begin
        if (done) state_next = rdata[LSR_DR] ? RX_RBR : IDLE;
      end
      RX_RBR: begin
        req_off = REG_RBR_THR;
        if (done) state_next = IDLE;
      end
      default: state_next = INIT_DLAB;
    endcase
  end

  assign start = (state != IDLE) && !CYC_O;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= INIT_DLAB;
      init_done <= 1'b0;
      tx_full   <= 1'b0;
      last_tx   <= 1'b0;
      poll_cnt  <= 16'h0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state    <= state_next;
      rx_valid <= 1'b0;
      if (state == INIT_IER && done) init_done <= 1'b1;
      // A THR write that times out keeps the byte so it is retried later.
      if (tx_accept) tx_full <= 1'b1;
      else if (state == TX_THR && done && !timeout) tx_full <= 1'b0;
      if (grant_tx) last_tx <= 1'b1;
      else if (grant_rx) last_tx <= 1'b0;
      if (grant_rx) poll_cnt <= 16'h0;
      else if (state == IDLE && poll_cnt != POLL_MAX) poll_cnt <= poll_cnt + 16'd1;
      if (state == RX_RBR && done && !timeout) begin
        rx_data  <= rdata;
        rx_valid <= 1'b1;
      end
      if (timeout) bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (tx_accept) tx_buf <= tx_data;
  end

endmodule

// File: tb/tb_uart_8250_ctrl.sv
// Scoreboard bench for uart_8250_ctrl with a behavioural uart_8250 slave.
module tb_uart_8250_ctrl;

  localparam logic [31:0] BASE = 32'h1250_0000;

  typedef struct packed {
    logic       we;
    logic [2:0] off;
    logic [7:0] data;
  } txn_t;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I = 32'h0;
  logic        WE_O;
  logic [3:0]  SEL_O;
  logic        STB_O;
  logic        ACK_I = 1'b0;
  logic        CYC_O;
  logic        INT_I = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        init_done;
  logic        bus_err;
  logic        err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  txn_t       exp_bus[$];
  logic [7:0] exp_rx[$];
  txn_t       mon_e;
  logic [7:0] mon_rx;
  logic       mon_prev_stb = 1'b0;
  logic       mon_prev_rxv = 1'b0;

  logic [7:0] rx_mem[16];
  int         rx_wr = 0;
  int         rx_rd = 0;
  int         lsr_reads = 0;
  int         thre_ready_at = 0;
  logic       block_dll = 1'b0;
  logic       block_thr = 1'b0;
  int         blocked_cycles = 0;
  logic [2:0] s_off;
  logic       s_blk;

  uart_8250_ctrl #(
    .BASE_ADDR     (BASE),
    .DIVISOR       (16'h0003),
    .LCR_FMT       (8'h03),
    .POLL_INTERVAL (60000),
    .ACK_TIMEOUT   (255)
  ) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .ADR_O     (ADR_O),
    .DAT_O     (DAT_O),
    .DAT_I     (DAT_I),
    .WE_O      (WE_O),
    .SEL_O     (SEL_O),
    .STB_O     (STB_O),
    .ACK_I     (ACK_I),
    .CYC_O     (CYC_O),
    .INT_I     (INT_I),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .init_done (init_done),
    .bus_err   (bus_err),
    .err_clr   (err_clr)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic exp_wr(input logic [2:0] off, input logic [7:0] data);
    exp_bus.push_back('{we: 1'b1, off: off, data: data});
  endtask

  task automatic exp_rd(input logic [2:0] off);
    exp_bus.push_back('{we: 1'b0, off: off, data: 8'h00});
  endtask

  task automatic exp_init();
    exp_wr(3'd3, 8'h80);
    exp_wr(3'd0, 8'h03);
    exp_wr(3'd1, 8'h00);
    exp_wr(3'd3, 8'h03);
    exp_wr(3'd2, 8'h07);
    exp_wr(3'd1, 8'h01);
  endtask

  // uart_8250 slave: zero-wait ACK, LSR built from its own THRE/RX state
  always @(negedge CLK_I) begin
    if (CYC_O && STB_O && !ACK_I) begin
      s_off = ADR_O[2:0];
      s_blk = WE_O && (s_off == 3'd0) &&
              ((block_dll && !init_done) || (block_thr && init_done));
      if (s_blk) begin
        blocked_cycles++;
      end else begin
        ACK_I = 1'b1;
        DAT_I = 32'hA5A5_A500;
        if (!WE_O && s_off == 3'd5) begin
          DAT_I[5] = (lsr_reads >= thre_ready_at);
          DAT_I[0] = (rx_wr != rx_rd);
          lsr_reads++;
        end else if (!WE_O && s_off == 3'd0 && rx_wr != rx_rd) begin
          DAT_I[7:0] = rx_mem[rx_rd];
          rx_rd++;
        end
      end
    end else begin
      ACK_I = 1'b0;
    end
    INT_I = (rx_wr != rx_rd);
  end

  // monitor: compare each new bus cycle and each rx_valid against the queues
  always @(negedge CLK_I) begin
    if (STB_O && !mon_prev_stb) begin
      if (exp_bus.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL bus_unexpected: got we=%0b adr=%h dat=%h, required no cycle", WE_O, ADR_O, DAT_O);
      end else begin
        mon_e = exp_bus.pop_front();
        check("bus_txn {we,adr,dat,sel,cyc}",
              {WE_O, ADR_O, (WE_O ? DAT_O : 32'h0), SEL_O, CYC_O},
              {mon_e.we, BASE + {29'd0, mon_e.off}, (mon_e.we ? {24'h0, mon_e.data} : 32'h0), 4'b0001, 1'b1});
      end
      if (WE_O && ADR_O == BASE && init_done) check("tx_ready_during_thr", tx_ready, 1'b0);
    end
    if (rx_valid) begin
      check("rx_valid_one_cycle", mon_prev_rxv, 1'b0);
      if (exp_rx.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got rx_data=%h, required no rx_valid", rx_data);
      end else begin
        mon_rx = exp_rx.pop_front();
        check("rx_data", rx_data, mon_rx);
      end
    end
    mon_prev_stb = STB_O;
    mon_prev_rxv = rx_valid;
  end

  task automatic check_reset_outputs(input string name);
    check(name, {CYC_O, STB_O, SEL_O, WE_O, ADR_O, DAT_O},
          {1'b0, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h0});
    check({name, "_ctl"}, {init_done, tx_ready, rx_valid, bus_err, rx_data}, 12'h000);
  endtask

  task automatic wait_init(input int budget);
    int i = 0;
    while (!init_done && i < budget) begin
      @(negedge CLK_I);
      i++;
    end
    check("init_done", init_done, 1'b1);
  endtask

  task automatic drain(input string name, input int budget);
    int i = 0;
    while ((exp_bus.size() != 0 || exp_rx.size() != 0 || CYC_O) && i < budget) begin
      @(negedge CLK_I);
      i++;
    end
    repeat (4) @(negedge CLK_I);
    check(name, exp_bus.size() + exp_rx.size(), 0);
  endtask

  task automatic send_tx(input logic [7:0] b);
    int i = 0;
    while (!tx_ready && i < 500) begin
      @(negedge CLK_I);
      i++;
    end
    check("tx_ready_before_send", tx_ready, 1'b1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge CLK_I);
    tx_valid = 1'b0;
    check("tx_ready_after_accept", tx_ready, 1'b0);
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr] = b;
    rx_wr++;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int i;
    RST_I    = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    err_clr  = 1'b0;

    // reset and the six-write init sequence
    repeat (3) @(negedge CLK_I);
    check_reset_outputs("reset_outputs");
    exp_init();
    RST_I = 1'b0;
    wait_init(200);
    drain("init_sequence", 50);
    check("bus_err_after_init", bus_err, 1'b0);

    // single byte, THRE already set
    exp_rd(3'd5);
    exp_wr(3'd0, 8'h12);
    send_tx(8'h12);
    drain("tx_12", 100);
    check("tx_ready_after_thr", tx_ready, 1'b1);

    // THRE low for three polls, then the byte goes out once
    thre_ready_at = lsr_reads + 3;
    repeat (4) exp_rd(3'd5);
    exp_wr(3'd0, 8'h34);
    send_tx(8'h34);
    drain("tx_34_retry", 200);
    check("thre_polls_used", lsr_reads, thre_ready_at + 1);

    // interrupt-driven receive
    exp_rd(3'd5);
    exp_rd(3'd0);
    exp_rx.push_back(8'h56);
    push_rx(8'h56);
    drain("rx_56", 100);
    check("rx_data_holds", rx_data, 8'h56);

    // TX and RX both pending: grants go TX, RX, TX
    thre_ready_at = lsr_reads + 1;
    exp_rd(3'd5);
    exp_rd(3'd5);
    exp_rd(3'd0);
    exp_rd(3'd5);
    exp_wr(3'd0, 8'h77);
    exp_rx.push_back(8'h9A);
    send_tx(8'h77);
    push_rx(8'h9A);
    drain("alternate_tx_rx", 200);
    check("rx_data_after_alt", rx_data, 8'h9A);

    // DLL write never acknowledged: timeout, flag, sequence continues
    @(negedge CLK_I);
    RST_I = 1'b1;
    #1;
    check_reset_outputs("reset2_outputs");
    @(negedge CLK_I);
    block_dll      = 1'b1;
    blocked_cycles = 0;
    exp_init();
    RST_I = 1'b0;
    wait_init(600);
    drain("init_with_timeout", 50);
    block_dll = 1'b0;
    check("dll_stb_cycles", blocked_cycles, 255);
    check("bus_err_set", bus_err, 1'b1);
    repeat (5) @(negedge CLK_I);
    check("bus_err_sticky", bus_err, 1'b1);
    err_clr = 1'b1;
    @(negedge CLK_I);
    err_clr = 1'b0;
    check("bus_err_cleared", bus_err, 1'b0);

    // reset while the THR write is waiting for ACK
    block_thr = 1'b1;
    exp_rd(3'd5);
    exp_wr(3'd0, 8'h5C);
    send_tx(8'h5C);
    i = 0;
    while (!(STB_O && WE_O && ADR_O == BASE) && i < 300) begin
      @(negedge CLK_I);
      i++;
    end
    check("thr_cycle_seen", STB_O && WE_O && ADR_O == BASE, 1'b1);
    @(negedge CLK_I);
    check("thr_cycle_started", exp_bus.size(), 0);
    RST_I = 1'b1;
    #1;
    check("reset_drops_cyc_stb", {CYC_O, STB_O}, 2'b00);
    check_reset_outputs("reset3_outputs");
    block_thr = 1'b0;
    exp_init();
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b0;
    wait_init(200);
    drain("init_after_mid_reset", 50);
    repeat (60) @(negedge CLK_I);
    check("tx_buffer_empty_after_reset", tx_ready, 1'b1);
    check("no_stale_thr", exp_bus.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
